// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit: bit-serial 4-bit a - b - bin, LSB first, one bit per cycle.
// Define OVERFLOW_DETECT_EN to add the registered signed-overflow output ovf_o.
module serial_subtractor_4bit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] diff_o,
  output logic       bout_o,
  output logic       bout3_o
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic       ovf_o
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] a_q, b_q, acc_q;
  logic [1:0] idx_q;
  logic br_q, d, br_nx, last;
  assign d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last = idx_q == 2'd3;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start_i) state_nx = CALC;
    else if (state == CALC && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
    busy_o = state == CALC;
    done_o = state == DONE;
  end
  // Operands shift right so bit 0 is always the current bit; result bits enter acc_q from the top.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
      br_q <= 1'b0;
      acc_q <= '0;
      idx_q <= '0;
      diff_o <= '0;
      bout_o <= 1'b0;
      bout3_o <= 1'b0;
    end else if (state == IDLE && start_i) begin
      a_q <= a_i;
      b_q <= b_i;
      br_q <= bin_i;
      idx_q <= '0;
    end else if (state == CALC) begin
      a_q <= {1'b0, a_q[3:1]};
      b_q <= {1'b0, b_q[3:1]};
      br_q <= br_nx;
      acc_q <= {d, acc_q[3:1]};
      idx_q <= idx_q + 2'd1;
      if (last) begin
        diff_o <= {d, acc_q[3:1]};
        bout_o <= br_nx;
        bout3_o <= br_q;
      end
    end
`ifdef OVERFLOW_DETECT_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ovf_o <= 1'b0;
    else if (state == CALC && last) ovf_o <= br_nx ^ br_q;
`endif
endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port a_i, input, 4 bits: minuend, sampled only on an accepted start.
REQ-004 SHALL have port b_i, input, 4 bits: subtrahend, sampled only on an accepted start.
REQ-005 SHALL have port bin_i, input, 1 bit: borrow-in, sampled only on an accepted start.
REQ-006 SHALL have port start_i, input, 1 bit: operation request.
REQ-007 SHALL have port busy_o, output, 1 bit: high while in CALC.
REQ-008 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port diff_o, output, 4 bits: registered result a - b - bin, mod 16.
REQ-010 SHALL have port bout_o, output, 1 bit: borrow out of bit 3.
REQ-011 SHALL have port bout3_o, output, 1 bit: borrow out of bit 2, i.e. the borrow into bit 3.
REQ-012 SHALL have port ovf_o, output, 1 bit, present only when OVERFLOW_DETECT_EN is defined.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE with start_i=1 at a clock edge, latch a_i, b_i and bin_i, clear the bit index to 0 and enter CALC.
REQ-015 SHALL, in CALC, process exactly one bit per cycle, LSB first:
- d = a ^ b ^ br
- br_next = (~a & b) | (~(a ^ b) & br)
- br starts at the latched bin_i.
REQ-016 SHALL, on the edge that processes bit 3, enter DONE and in the same edge update diff_o, bout_o and bout3_o (and ovf_o when enabled).
REQ-017 SHALL assert done_o for exactly the one cycle spent in DONE, then return to IDLE.
REQ-018 SHALL give a fixed latency: start accepted at edge k -> results valid and done_o high after edge k+4.
REQ-019 SHALL ignore start_i in CALC and DONE; no re-latch and no restart.
REQ-020 SHALL hold diff_o, bout_o and bout3_o (and ovf_o) at the previous result from the accepting edge until the completion edge; no partial results are visible.
REQ-021 SHALL drive busy_o high in CALC only.
REQ-022 SHALL perform all arithmetic modulo 16 with no output width extension.

Reset
REQ-023 SHALL, while rst_ni=0, immediately force:
- state to IDLE and the bit index to 0
- busy_o=0, done_o=0
- diff_o=4'h0, bout_o=0, bout3_o=0, ovf_o=0
- internal operand and borrow registers to 0.
REQ-024 SHALL, on reset during CALC, abort the operation with no done_o pulse and leave the outputs at their reset values.
REQ-025 SHALL accept a start on the first clock edge after rst_ni deasserts.

Configuration
REQ-026 SHALL, when OVERFLOW_DETECT_EN is defined, provide ovf_o = bout_o ^ bout3_o (signed two's-complement overflow), registered with the other results.
REQ-027 SHALL, when OVERFLOW_DETECT_EN is undefined, omit the ovf_o port and its logic entirely; all other behaviour is unchanged.

Verification
REQ-028 SHALL cover: a=7, b=3, bin=0, start -> after 4 cycles done_o=1, diff_o=4'h4, bout_o=0, bout3_o=0.
REQ-029 SHALL cover: a=3, b=7, bin=0 -> diff_o=4'hC, bout_o=1, bout3_o=1, ovf_o=0.
REQ-030 SHALL cover: a=8, b=1, bin=0 -> diff_o=4'h7, bout_o=0, bout3_o=1, ovf_o=1 (macro defined); ovf_o absent when the macro is undefined.
REQ-031 SHALL cover: a=0, b=0, bin=1 -> diff_o=4'hF, bout_o=1, bout3_o=1.
REQ-032 SHALL cover: start_i held high with new operands during CALC -> ignored; exactly one done_o pulse, with the result from the originally latched operands.
REQ-033 SHALL cover: rst_ni pulsed low in the 2nd CALC cycle -> no done_o, all outputs 0, busy_o=0; a new start afterwards completes normally.
